// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 types for the slave memory responder: burst and response codes, FSM states,
// and the burst legality check used by both channels.
package axi4_globals_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2,
    BurstRsvd  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExokay = 2'd1,
    RespSlverr = 2'd2,
    RespDecerr = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    StWIdle,
    StWData,
    StWResp
  } wstate_e;

  typedef enum logic [0:0] {
    StRIdle,
    StRData
  } rstate_e;

  // Reserved burst type and WRAP with a length other than 2/4/8/16 beats both answer SLVERR.
  function automatic logic burst_err(input burst_e burst, input logic [7:0] len);
    if (burst == BurstRsvd) return 1'b1;
    if (burst == BurstWrap) return !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return 1'b0;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; reserved type steps like INCR.
module axi4_burst_addr_gen import axi4_globals_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] stepped;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    stepped   = addr + incr;
    unique case (burst)
      BurstFixed: next_addr = addr;
      // Keep the bits above the wrap window, let the low bits roll over inside it.
      BurstWrap:  next_addr = (addr & ~wrap_mask) | (stepped & wrap_mask);
      default:    next_addr = stepped;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave backed by a word-addressed memory, independent read and write FSMs.
// Define AXI4_SLV_RANGE_CHECK_EN to reject beats outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH words).
module axi4_slave_mem_responder import axi4_globals_pkg::*; #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ID_WIDTH   = 4,
  parameter int unsigned            MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SHIFT      = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH);
`ifdef AXI4_SLV_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_e               w_state_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_next, w_off;
  logic [7:0]            w_len_q, w_beat_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_over_q, w_err_q, w_err_d, w_oor, w_we;
  logic [IDX_WIDTH-1:0]  w_idx;

  rstate_e               r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_next, r_fetch_addr, r_off;
  logic [7:0]            r_len_q, r_beat_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_berr_q, r_oor;
  logic [IDX_WIDTH-1:0]  r_idx;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_gen (
    .addr      (w_addr_q),
    .size      (w_size_q),
    .len       (w_len_q),
    .burst     (w_burst_q),
    .next_addr (w_next)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_gen (
    .addr      (r_addr_q),
    .size      (r_size_q),
    .len       (r_len_q),
    .burst     (r_burst_q),
    .next_addr (r_next)
  );

  // Without range checking the word index simply aliases modulo MEM_DEPTH.
  always_comb begin
    w_off = w_addr_q - BASE_ADDR;
    w_idx = w_off[SHIFT +: IDX_WIDTH];
    w_oor = RangeCheck &&
            ((w_addr_q < BASE_ADDR) || ((w_off >> SHIFT) >= ADDR_WIDTH'(MEM_DEPTH)));
    w_we  = wready && wvalid && !w_over_q && !w_oor;
    w_err_d = w_err_q | w_oor;
    if (!w_over_q && (wlast != (w_beat_q == w_len_q))) w_err_d = 1'b1;
  end

  // The read port looks ahead: AR address while idle, next beat address while streaming.
  always_comb begin
    r_fetch_addr = (r_state_q == StRIdle) ? araddr : r_next;
    r_off = r_fetch_addr - BASE_ADDR;
    r_idx = r_off[SHIFT +: IDX_WIDTH];
    r_oor = RangeCheck &&
            ((r_fetch_addr < BASE_ADDR) || ((r_off >> SHIFT) >= ADDR_WIDTH'(MEM_DEPTH)));
  end

  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= StWIdle;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_over_q  <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      unique case (w_state_q)
        StWIdle: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_id_q    <= awid;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_beat_q  <= '0;
            w_over_q  <= 1'b0;
            w_err_q   <= burst_err(burst_e'(awburst), awlen);
            awready   <= 1'b0;
            wready    <= 1'b1;
            w_state_q <= StWData;
          end
        end
        StWData: begin
          if (wvalid && wready) begin
            w_addr_q <= w_next;
            w_beat_q <= w_beat_q + 8'd1;
            w_err_q  <= w_err_d;
            // Missing wlast on the final beat: keep accepting, but stop writing.
            if (!wlast && (w_beat_q == w_len_q)) w_over_q <= 1'b1;
            if (wlast) begin
              wready    <= 1'b0;
              bvalid    <= 1'b1;
              bid       <= w_id_q;
              bresp     <= w_err_d ? RespSlverr : RespOkay;
              w_state_q <= StWResp;
            end
          end
        end
        StWResp: begin
          if (bready) begin
            bvalid    <= 1'b0;
            awready   <= 1'b1;
            w_state_q <= StWIdle;
          end
        end
        default: w_state_q <= StWIdle;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= StRIdle;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_berr_q  <= 1'b0;
    end else begin
      unique case (r_state_q)
        StRIdle: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_beat_q  <= '0;
            r_berr_q  <= burst_err(burst_e'(arburst), arlen);
            arready   <= 1'b0;
            rvalid    <= 1'b1;
            rid       <= arid;
            rlast     <= (arlen == 8'd0);
            rdata     <= r_oor ? '0 : mem[r_idx];
            rresp     <= (burst_err(burst_e'(arburst), arlen) || r_oor) ? RespSlverr : RespOkay;
            r_state_q <= StRData;
          end
        end
        StRData: begin
          if (rready) begin
            if (rlast) begin
              rvalid    <= 1'b0;
              rlast     <= 1'b0;
              arready   <= 1'b1;
              r_state_q <= StRIdle;
            end else begin
              r_addr_q <= r_next;
              r_beat_q <= r_beat_q + 8'd1;
              rlast    <= ((r_beat_q + 8'd1) == r_len_q);
              rdata    <= r_oor ? '0 : mem[r_idx];
              rresp    <= (r_berr_q || r_oor) ? RespSlverr : RespOkay;
            end
          end
        end
        default: r_state_q <= StRIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Randomized scoreboard bench for axi4_slave_mem_responder against a word-array memory model.
module tb_axi4_slave_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned BASE  = 0;
`ifdef AXI4_SLV_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        aclk, aresetn;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  axi4_slave_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'(BASE))
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf_data [32];
  logic [3:0]  wbuf_strb [32];
  int          total = 0;
  int          bad = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1);
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Address of beat i from the burst rules, stated arithmetically.
  function automatic int unsigned beat_addr(input int unsigned addr, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned i);
    int unsigned nb, wb, base;
    nb = 1 << size;
    if (burst == 0) return addr;
    if (burst == 2) begin
      wb   = (len + 1) * nb;
      base = (addr / wb) * wb;
      return base + ((addr - base) + i * nb) % wb;
    end
    return addr + i * nb;
  endfunction

  function automatic int unsigned widx(input int unsigned a);
    return ((a - BASE) / 4) % DEPTH;
  endfunction

  function automatic bit oor(input int unsigned a);
    return RC && ((a < BASE) || (((a - BASE) / 4) >= DEPTH));
  endfunction

  function automatic bit burst_bad(input int unsigned burst, input int unsigned len);
    if (burst == 3) return 1'b1;
    if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  function automatic logic sel(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_high(input int which, input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge aclk);
      if (sel(which)) break;
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got low want high within 100 cycles", nm);
        break;
      end
    end
  endtask

  task automatic do_write(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                          input int unsigned size, input int unsigned burst,
                          input int unsigned last_beat);
    int unsigned a, n;
    bit err;
    err = burst_bad(burst, len) || (last_beat != len);
    for (int i = 0; i <= int'(last_beat) && i <= int'(len); i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (oor(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++)
        if (wbuf_strb[i][b]) model_mem[widx(a)][8*b +: 8] = wbuf_data[i][8*b +: 8];
    end
    exp_b.push_back('{id: id, resp: err ? 2'd2 : 2'd0});
    @(posedge aclk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size);
    awburst = 2'(burst);
    wait_high(0, "awready");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("w_latency", wready, 1'b1);
    @(posedge aclk); #1;
    for (int i = 0; i <= int'(last_beat); i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i];
      wlast = (i == int'(last_beat));
      wait_high(1, "wready");
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
    end
    @(negedge aclk);
    check("b_latency", bvalid, 1'b1);
    n = 0;
    while (exp_b.size() != 0 && n < 100) begin @(negedge aclk); n++; end
    if (exp_b.size() != 0) begin
      total++; bad++;
      $display("FAIL b_timeout: got %0d pending want 0", exp_b.size());
    end
  endtask

  task automatic do_read(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                         input int unsigned size, input int unsigned burst, input int stall_beat);
    int unsigned a;
    int st;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, size, burst, i);
      exp_r.push_back('{id: id, data: oor(a) ? 32'h0 : model_mem[widx(a)],
                        resp: (burst_bad(burst, len) || oor(a)) ? 2'd2 : 2'd0,
                        last: (i == int'(len))});
    end
    @(posedge aclk); #1;
    rready = 1'b0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size);
    arburst = 2'(burst);
    wait_high(2, "arready");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check("r_latency", rvalid, 1'b1);
    @(posedge aclk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      st = (i == stall_beat) ? 3 : int'($urandom_range(0, 2));
      if (st > 0) rready = 1'b0;
      repeat (st) begin @(posedge aclk); #1; end
      rready = 1'b1;
      wait_high(3, "rvalid");
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    @(negedge aclk);
    check("arready_after_rlast", arready, 1'b1);
  endtask

  task automatic rand_burst(input int unsigned region, output int unsigned addr,
                            output int unsigned len, output int unsigned size,
                            output int unsigned burst);
    int unsigned span;
    burst = $urandom_range(0, 2);
    size  = $urandom_range(0, 2);
    if (burst == 2) len = (1 << $urandom_range(1, 4)) - 1;
    else len = $urandom_range(0, 15);
    span = (burst == 1) ? ((len + 1) << size) : (1 << size);
    addr = region * 512 + (($urandom_range(0, (512 - span) >> size)) << size);
  endtask

  task automatic fill_wbuf(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      wbuf_data[i] = $urandom;
      wbuf_strb[i] = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk); #1;
      bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops expectations on every handshake and checks stall stability.
  initial begin
    logic        hold;
    logic [38:0] held;
    b_exp_t      eb;
    r_exp_t      er;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) hold = 1'b0;
      else begin
        if (hold) check("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, held});
        hold = rvalid && !rready;
        held = {rid, rdata, rresp, rlast};
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected: got id=%h resp=%h want none", bid, bresp);
          end else begin
            eb = exp_b.pop_front();
            check("b_resp", {bid, bresp}, eb);
          end
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected: got id=%h data=%h want none", rid, rdata);
          end else begin
            er = exp_r.pop_front();
            check("r_beat", {rid, rdata, rresp, rlast}, er);
          end
        end
      end
    end
  end

  initial begin
    int unsigned wa, wl, ws, wbu, ra, rl, rs, rbu, op, reg_w;
    int n;
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    check("reset_data", {bid, bresp, rid, rresp, rdata}, 44'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
      do_write(4'(k), k * 64, 15, 2, 1, 15);
    end

    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0 + i; wbuf_strb[i] = 4'hF; end
    do_write(4'h5, 32'h10, 3, 2, 1, 3);
    do_read(4'h6, 32'h10, 3, 2, 1, -1);
    do_read(4'h7, 32'h18, 3, 2, 2, -1);

    wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF;
    do_write(4'h1, 32'h80, 0, 2, 1, 0);
    wbuf_data[0] = 32'hFFFFFFFF; wbuf_strb[0] = 4'h3;
    do_write(4'h2, 32'h80, 0, 2, 1, 0);
    do_read(4'h3, 32'h80, 0, 2, 1, -1);

    do_read(4'h9, 32'h20, 3, 2, 1, 1);

    fill_wbuf(4);
    fork
      do_write(4'hA, 32'h100, 3, 2, 1, 1);
      do_read(4'hB, 32'h200, 7, 2, 1, -1);
    join
    fill_wbuf(6);
    do_write(4'hC, 32'h140, 3, 2, 1, 5);
    do_read(4'hD, 32'h140, 3, 2, 1, -1);

    fill_wbuf(2);
    do_write(4'hE, 32'h180, 1, 2, 3, 1);
    do_read(4'hE, 32'h180, 1, 2, 3, -1);
    fill_wbuf(1);
    do_write(4'h4, 32'h190, 0, 2, 2, 0);
    do_read(4'h4, 32'h190, 0, 2, 2, -1);

    wbuf_data[0] = 32'hCAFEF00D; wbuf_strb[0] = 4'hF;
    do_write(4'h1, BASE + DEPTH * 4, 0, 2, 1, 0);
    do_read(4'h2, BASE, 0, 2, 1, -1);
    do_read(4'h3, BASE + DEPTH * 4, 0, 2, 1, -1);

    // Abandon a read mid-burst; nothing is expected from it.
    @(posedge aclk); #1;
    rready = 1'b0; arvalid = 1'b1; arid = 4'h8; araddr = 32'h0; arlen = 8'd7;
    arsize = 3'd2; arburst = 2'd1;
    wait_high(2, "arready_rst");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_reset", {rvalid, rlast, arready, bvalid}, 4'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      reg_w = $urandom_range(0, 1);
      rand_burst(reg_w, wa, wl, ws, wbu);
      rand_burst(1 - reg_w, ra, rl, rs, rbu);
      fill_wbuf(wl + 1);
      if (op == 0) do_write(4'($urandom), wa, wl, ws, wbu, wl);
      else if (op == 1) do_read(4'($urandom), ra, rl, rs, rbu, -1);
      else fork
        do_write(4'($urandom), wa, wl, ws, wbu, wl);
        do_read(4'($urandom), ra, rl, rs, rbu, -1);
      join
    end

    n = 0;
    while ((exp_b.size() + exp_r.size()) != 0 && n < 200) begin @(negedge aclk); n++; end
    check("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
